// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_queue_pkg;
  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ptr.sv
// Wrap-bit queue pointer: increments modulo 2^W, synchronous clear wins over increment.
module fetch_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues in-order imem requests at pc_i, buffers PC-tagged responses
// in a circular queue for decode, and discards in-flight responses after a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = fetch_queue_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pc4_o,
  input  logic            id_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (XLEN != fetch_queue_pkg::XLEN) begin : g_bad_xlen
    $error("fetch_queue: XLEN must match fetch_queue_pkg::XLEN");
  end

  logic [PW-1:0] alloc_q, fill_q, read_q, occ;
  logic [PW-1:0] drop_q, drop_d;
  logic          full, empty, req_fire, rsp_wr, deq;
  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  head;

  assign occ   = alloc_q - read_q;
  assign full  = (occ == PW'(DEPTH));
  assign empty = (alloc_q == read_q);

  assign imem_req_valid_o = rst && !full && !flush_i;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign pc_en_o          = req_fire;
  assign imem_addr_o      = pc_i;

  // Responses owed to pre-redirect requests are swallowed while drop_q is nonzero.
  assign rsp_wr = imem_rsp_valid_i && (drop_q == '0) && !flush_i;

  assign head       = entries_q[read_q[AW-1:0]];
  assign if_valid_o = !empty && head.filled;
  assign deq        = if_valid_o && id_ready_i;
  assign if_instr_o = if_valid_o ? head.instr : '0;
  assign if_pc_o    = if_valid_o ? head.pc : '0;
  assign if_pc4_o   = if_valid_o ? head.pc + XLEN'(PC_STEP) : '0;

  fetch_ptr #(.W(PW)) u_alloc (
    .clk(clk), .rst(rst), .clr_i(flush_i), .inc_i(req_fire), .ptr_o(alloc_q)
  );
  fetch_ptr #(.W(PW)) u_fill (
    .clk(clk), .rst(rst), .clr_i(flush_i), .inc_i(rsp_wr), .ptr_o(fill_q)
  );
  fetch_ptr #(.W(PW)) u_read (
    .clk(clk), .rst(rst), .clr_i(flush_i), .inc_i(deq), .ptr_o(read_q)
  );

  // On redirect, everything issued but unanswered becomes a drop, minus the
  // response (dropped or not) that is being consumed this same edge.
  always_comb begin
    drop_d = drop_q;
    if (flush_i)
      drop_d = drop_q + (alloc_q - fill_q) - PW'(imem_rsp_valid_i);
    else if (imem_rsp_valid_i && (drop_q != '0))
      drop_d = drop_q - PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  // Slot indices never collide: fill==alloc implies no response, read==alloc
  // implies empty (no dequeue) or full (no request).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (req_fire) begin
        entries_q[alloc_q[AW-1:0]].pc     <= pc_i;
        entries_q[alloc_q[AW-1:0]].filled <= 1'b0;
      end
      if (rsp_wr) begin
        entries_q[fill_q[AW-1:0]].instr  <= imem_rsp_data_i;
        entries_q[fill_q[AW-1:0]].filled <= 1'b1;
      end
      if (deq) entries_q[read_q[AW-1:0]].filled <= 1'b0;
    end
  end

  a_fill_le_alloc: assert property (@(posedge clk) disable iff (!rst)
    (alloc_q - fill_q) <= PW'(DEPTH));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
    drop_q <= PW'(DEPTH));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid_i |-> (drop_q != '0) || (alloc_q != fill_q));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC generator and in-order fixed-latency imem model.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] OFF   = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_en_o;
  logic        flush_i = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        if_valid_o;
  logic [31:0] if_instr_o, if_pc_o, if_pc4_o;
  logic        id_ready_i = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_en_o(pc_en_o), .flush_i(flush_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .if_valid_o(if_valid_o),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .if_pc4_o(if_pc4_o),
    .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        mq[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] tgt = '0;
  logic        s_fire, s_valid, s_deq;
  logic [31:0] s_addr, s_pc, s_instr, s_pc4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive due response, snapshot outputs at negedge, advance PC after posedge.
  task automatic tick();
    rsp_t r;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mq[0].data;
      r = mq.pop_front();
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    @(negedge clk);
    s_fire  = pc_en_o;
    s_addr  = imem_addr_o;
    s_valid = if_valid_o;
    s_pc    = if_pc_o;
    s_instr = if_instr_o;
    s_pc4   = if_pc4_o;
    s_deq   = if_valid_o && id_ready_i;
    if (s_fire) begin
      r.due  = cyc + lat;
      r.data = imem_addr_o + OFF;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    if (flush_i)     pc_i = tgt;
    else if (s_fire) pc_i = pc_i + 32'd4;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_i = 1'b0;
    pc_i = '0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, first, stale, got;
    logic [31:0] fpc, finstr;
    logic        exp_rdy;

    #2;
    chk("rst_if_valid", {31'd0, if_valid_o}, 0);
    chk("rst_req_valid", {31'd0, imem_req_valid_o}, 0);
    chk("rst_pc_en", {31'd0, pc_en_o}, 0);
    chk("rst_instr", if_instr_o, 0);
    chk("rst_pc", if_pc_o, 0);
    chk("rst_pc4", if_pc4_o, 0);

    // first instruction latency and steady-state streaming
    do_reset();
    lat = 1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    tick();
    chk("t1_c0_fire", {31'd0, s_fire}, 1);
    chk("t1_c0_addr", s_addr, 32'h0);
    chk("t1_c0_vld", {31'd0, s_valid}, 0);
    tick();
    chk("t1_c1_vld", {31'd0, s_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_vld", {31'd0, s_valid}, 1);
      chk("t1_pc", s_pc, k * 4);
      chk("t1_instr", s_instr, OFF + k * 4);
      chk("t1_pc4", s_pc4, k * 4 + 4);
    end

    // decode stall fills the queue, then drains in order
    do_reset();
    id_ready_i = 1'b0; n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_fire) n++;
    end
    chk("t2_fires", n, 4);
    chk("t2_pc_en_held", {31'd0, s_fire}, 0);
    chk("t2_head_vld", {31'd0, s_valid}, 1);
    chk("t2_head_pc", s_pc, 32'h0);
    id_ready_i = 1'b1;
    tick();
    chk("t2_d0_pc", s_pc, 32'h0);
    chk("t2_d0_fire", {31'd0, s_fire}, 0);
    tick();
    chk("t2_d1_pc", s_pc, 32'h4);
    chk("t2_d1_fire", {31'd0, s_fire}, 1);
    chk("t2_d1_addr", s_addr, 32'h10);
    tick(); chk("t2_d2_pc", s_pc, 32'h8);
    tick(); chk("t2_d3_pc", s_pc, 32'hC);
    tick(); chk("t2_d4_pc", s_pc, 32'h10);

    // redirect with three requests in flight on a slow memory
    do_reset();
    lat = 4;
    repeat (3) tick();
    flush_i = 1'b1; tgt = 32'h100;
    tick();
    chk("t3_flush_nofire", {31'd0, s_fire}, 0);
    flush_i = 1'b0;
    first = -1; stale = 0; fpc = '0; finstr = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_valid) begin
        if (first < 0) begin
          first = cyc - 1; fpc = s_pc; finstr = s_instr;
        end
        if (s_pc < 32'h100) stale++;
      end
    end
    chk("t3_first_cyc", first, 9);
    chk("t3_first_pc", fpc, 32'h100);
    chk("t3_first_instr", finstr, 32'h1000_0100);
    chk("t3_stale", stale, 0);

    // redirect coinciding with a response and a dequeue
    do_reset();
    lat = 1;
    tick(); tick();
    flush_i = 1'b1; tgt = 32'h200;
    tick();
    chk("t4_flush_handoff", {31'd0, s_deq}, 1);
    chk("t4_flush_pc", s_pc, 32'h0);
    flush_i = 1'b0;
    tick();
    chk("t4_empty", {31'd0, s_valid}, 0);
    chk("t4_fire", {31'd0, s_fire}, 1);
    chk("t4_addr", s_addr, 32'h200);
    tick();
    chk("t4_c4_vld", {31'd0, s_valid}, 0);
    tick();
    chk("t4_c5_vld", {31'd0, s_valid}, 1);
    chk("t4_c5_pc", s_pc, 32'h200);
    chk("t4_c5_instr", s_instr, 32'h1000_0200);

    // request backpressure toggling; PC stream must be gap- and duplicate-free
    do_reset();
    lat = 1; id_ready_i = 1'b1; got = 0;
    for (int k = 0; k < 100 && got < 16; k++) begin
      exp_rdy = (k % 2 == 0);
      imem_req_ready_i = exp_rdy;
      tick();
      chk("t5_fire", {31'd0, s_fire}, {31'd0, exp_rdy});
      if (s_deq) begin
        chk("t5_pc", s_pc, got * 4);
        chk("t5_instr", s_instr, OFF + got * 4);
        got++;
      end
    end
    chk("t5_count", got, 16);
    imem_req_ready_i = 1'b1;

    // async reset with a partly filled queue
    do_reset();
    lat = 1; id_ready_i = 1'b0;
    repeat (3) tick();
    #2;
    chk("t6_pre_vld", {31'd0, if_valid_o}, 1);
    rst = 1'b0;
    #1;
    chk("t6_vld", {31'd0, if_valid_o}, 0);
    chk("t6_req_vld", {31'd0, imem_req_valid_o}, 0);
    chk("t6_pc_en", {31'd0, pc_en_o}, 0);
    chk("t6_pc", if_pc_o, 0);
    chk("t6_instr", if_instr_o, 0);
    chk("t6_pc4", if_pc4_o, 0);
    do_reset();
    id_ready_i = 1'b1;
    tick();
    chk("t6_re_addr", s_addr, 32'h0);
    chk("t6_re_fire", {31'd0, s_fire}, 1);
    tick(); tick();
    chk("t6_re_vld", {31'd0, s_valid}, 1);
    chk("t6_re_pc", s_pc, 32'h0);
    chk("t6_re_instr", s_instr, OFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
